// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - switch debounce/decode and safe-point mode commit sequencer
module mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 4194304
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  switch,
  input  logic        pipe_idle,
  input  logic        frame_vs,
  output logic [3:0]  mode,
  output logic [15:0] led,
  output logic        mode_load,
  output logic        pipe_stop,
  output logic        busy,
  output logic        drain_timeout
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_WAIT_FRAME,
    ST_LOAD
  } state_t;

  // Only the six "thermometer" switch patterns select a mode; anything else is mode 0.
  function automatic logic [3:0] decode_code(input logic [5:0] sw);
    case (sw)
      6'b000001: return 4'd1;
      6'b000011: return 4'd2;
      6'b000111: return 4'd4;
      6'b001111: return 4'd5;
      6'b011111: return 4'd3;
      6'b111111: return 4'd6;
      default:   return 4'd0;
    endcase
  endfunction

  // LED image follows the switch position (one LED per valid pattern), active low.
  function automatic logic [15:0] code_led(input logic [3:0] code);
    case (code)
      4'd1:    return 16'hFFFE;
      4'd2:    return 16'hFFFD;
      4'd4:    return 16'hFFFB;
      4'd5:    return 16'hFFF7;
      4'd3:    return 16'hFFEF;
      4'd6:    return 16'hFFDF;
      default: return 16'hFFFF;
    endcase
  endfunction

  logic [5:0]        sync1_q, sync1_d;
  logic [5:0]        sw_s_q, sw_s_d;
  logic [5:0]        sw_prev_q, sw_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        stable_q, stable_d;

  state_t            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        mode_q, mode_d;
  logic [15:0]       led_q, led_d;
  logic              mode_load_q, mode_load_d;
  logic              pipe_stop_q, pipe_stop_d;
  logic              drain_timeout_q, drain_timeout_d;

  // Synchronize the raw switches and accept a vector only after it has been stable long enough.
  always_comb begin
    sync1_d   = switch;
    sw_s_d    = sync1_q;
    sw_prev_d = sw_s_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    if (sw_s_q != sw_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The equality guard stops a saturated count from accepting the very first changed sample.
    if ((sw_s_q == sw_prev_q) && (cnt_q == CNT_MAX)) begin
      stable_d = decode_code(sw_s_q);
    end
  end

  // Mode change sequencing: drain the pipeline, wait for a frame boundary, then commit.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    tcnt_d          = tcnt_q;
    mode_d          = mode_q;
    led_d           = led_q;
    drain_timeout_d = drain_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (stable_q != mode_q) begin
          pending_d = stable_q;
          tcnt_d    = '0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (stable_q == mode_q) begin
          state_d = ST_RUN;
        end else begin
          pending_d = stable_q;
          if (pipe_idle) begin
            state_d = ST_WAIT_FRAME;
          end else if (tcnt_q == TCNT_MAX) begin
            drain_timeout_d = 1'b1;
            state_d         = ST_WAIT_FRAME;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_FRAME: begin
        if (stable_q == mode_q) begin
          state_d = ST_RUN;
        end else begin
          pending_d = stable_q;
          if (frame_vs) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        mode_d  = pending_q;
        led_d   = code_led(pending_q);
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Registered from the next state so both flags line up exactly with the state they describe.
    mode_load_d = (state_d == ST_LOAD);
    pipe_stop_d = (state_d != ST_RUN);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= '0;
      sw_s_q          <= '0;
      sw_prev_q       <= '0;
      cnt_q           <= '0;
      stable_q        <= '0;
      state_q         <= ST_RUN;
      pending_q       <= '0;
      tcnt_q          <= '0;
      mode_q          <= '0;
      led_q           <= 16'hFFFF;
      mode_load_q     <= 1'b0;
      pipe_stop_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sw_s_q          <= sw_s_d;
      sw_prev_q       <= sw_prev_d;
      cnt_q           <= cnt_d;
      stable_q        <= stable_d;
      state_q         <= state_d;
      pending_q       <= pending_d;
      tcnt_q          <= tcnt_d;
      mode_q          <= mode_d;
      led_q           <= led_d;
      mode_load_q     <= mode_load_d;
      pipe_stop_q     <= pipe_stop_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign mode          = mode_q;
  assign led           = led_q;
  assign mode_load     = mode_load_q;
  assign pipe_stop     = pipe_stop_q;
  assign busy          = (state_q != ST_RUN);
  assign drain_timeout = drain_timeout_q;

endmodule
